rv32m_divider: RTL and testbench

//  Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU, used by the EX stage of rv32i_core.

---
 rtl/rv32m_divider.sv | 137 +++++++++++++
 tb/tb_rv32m_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rv32m_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; one result bit per cycle.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete straight from IDLE.
module rv32m_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvsr;
  logic            want_rem, q_neg, r_neg, div_zero;

  // Operand conditioning at start: op[0]=1 selects the unsigned variants.
  logic            is_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[XLEN-1];
  assign b_neg     = is_signed & divisor[XLEN-1];
  assign a_abs     = a_neg ? -dividend : dividend;
  assign b_abs     = b_neg ? -divisor  : divisor;

  // quo starts as |dividend|, shifts its MSB into the partial remainder and fills with quotient bits.
  logic [XLEN:0]   shifted, rem_next;
  logic [XLEN+1:0] diff;
  logic            ge;
  logic [XLEN-1:0] quo_next, q_fix, r_fix, final_res;

  assign shifted  = {rem[XLEN-1:0], quo[XLEN-1]};
  assign diff     = {1'b0, shifted} - {2'b00, dvsr};
  assign ge       = ~diff[XLEN+1];
  assign rem_next = ge ? diff[XLEN:0] : shifted;
  assign quo_next = {quo[XLEN-2:0], ge};

  // Divide-by-zero leaves |dividend| in the remainder, so only the quotient needs overriding;
  // MIN / -1 naturally yields quotient MIN and remainder 0 from the magnitudes.
  assign q_fix     = div_zero ? '1 : (q_neg ? -quo_next : quo_next);
  assign r_fix     = r_neg ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
  assign final_res = want_rem ? r_fix : q_fix;

`ifdef DIV_FAST_SPECIAL_EN
  logic            special, overflow;
  logic [XLEN-1:0] special_res;

  assign overflow    = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  assign special     = (divisor == '0) || overflow;
  assign special_res = (divisor == '0) ? (op[1] ? dividend : '1)
                                       : (op[1] ? '0 : dividend);
`endif

  // NOTE: every register here, including the operand/datapath registers, is async-reset so
  // the block comes out of reset in a fully defined state; all updates use non-blocking <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      want_rem <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            want_rem <= op[1];
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            div_zero <= (divisor == '0);
            rem      <= '0;
            quo      <= a_abs;
            dvsr     <= b_abs;
            count    <= '0;
            busy     <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
            if (special) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= special_res;
            end else begin
              state  <= RUN;
            end
`else
            state    <= RUN;
`endif
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem   <= rem_next;
            quo   <= quo_next;
            count <= count + 1'b1;
            if (count == CW'(XLEN-1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= final_res;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed scoreboard bench for rv32m_divider: results, latency, busy window, flush, reset.
// Define DIV_FAST_SPECIAL_EN for both RTL and bench to check the fast special-case path.
module tb_rv32m_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_s = 2'b00;
  logic [31:0] dividend_s = '0;
  logic [31:0] divisor_s = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  rv32m_divider #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_s),
    .dividend(dividend_s), .divisor(divisor_s), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built on the language's signed/unsigned operators plus RISC-V special cases.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: if (b == 0) return 32'hFFFF_FFFF;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
             else return sa / sb;
      2'b01: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      2'b10: if (b == 0) return a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
             else return sa % sb;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction

  // Called just after a falling edge; that cycle is cycle 0. inject_cyc>0 raises a stray
  // start in that cycle, which the busy divider must ignore.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inject_cyc);
    exp_t e;
    int   t0, lat, busy_bad;
    bit   seen;
    e.res = model(op, a, b);
    e.lat = latency(op, a, b);
    sb_q.push_back(e);
    op_s = op; dividend_s = a; divisor_s = b; start = 1'b1;
    t0 = cyc; lat = 0; busy_bad = 0; seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      if (n == inject_cyc) begin
        op_s = ~op; dividend_s = ~a; divisor_s = b + 32'd3; start = 1'b1;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        lat = cyc - t0;
        break;
      end
    end
    e = sb_q.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_result"}, result, e.res);
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_after_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic expect_quiet(input string tag, input int ncyc);
    int dones;
    dones = 0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    check(tag, 32'(dones), 32'd0);
  endtask

  initial begin
    logic [31:0] prev, ra, rb;
    logic [1:0]  rop;

    #2;
    check("reset_state", {busy, done, result[29:0]}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 0);
    run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 0);
    run_op("divu_max_2", 2'b01, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("divu_by0", 2'b01, 32'h1234_5678, 32'd0, 0);
    run_op("remu_by0", 2'b11, 32'h1234_5678, 32'd0, 0);
    run_op("div_neg_by0", 2'b00, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("rem_neg_by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_m7_m2", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 0);

    // Stray starts while busy and during the done cycle must not launch a second operation.
    run_op("ignore_mid", 2'b01, 32'd1000, 32'd9, 5);
    run_op("ignore_done", 2'b00, 32'hFFFF_FC18, 32'd9, 33);
    expect_quiet("no_second_done", 40);

    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op("random", rop, ra, rb, 0);
    end

    // Flush in cycle 10 of an operation, restart in cycle 12.
    prev = result;
    op_s = 2'b01; dividend_s = 32'd5000; divisor_s = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_low", {30'd0, busy, done}, 32'd0);
    check("flush_result_kept", result, prev);
    @(negedge clk);
    run_op("after_flush", 2'b10, 32'hFFFF_F000, 32'd7, 0);

    // Flush and start together in IDLE: flush wins.
    flush = 1'b1; start = 1'b1; op_s = 2'b01; dividend_s = 32'd50; divisor_s = 32'd5;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_start_idle", {31'd0, busy}, 32'd0);
    expect_quiet("flush_start_quiet", 40);

    // Asynchronous reset in the middle of a run.
    op_s = 2'b00; dividend_s = 32'd77; divisor_s = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {30'd0, busy, done}, 32'd0);
    check("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", 2'b00, 32'd77, 32'd5, 0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
